// File: rtl/memory_bus_ctrl_pkg.sv
// memory_bus_ctrl_pkg: shared types for the two-core coherent memory bus controller
package memory_bus_ctrl_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
  typedef enum logic [3:0] {IDLE, WB1, WB2, INV, SNOOP, C2C1, C2C2, RAM1, RAM2, IFETCH} bus_state_t;
endpackage

// File: rtl/memory_bus_ctrl_rr_arbiter.sv
// rr_arbiter: two-way round-robin grant; the pointed-to side wins when both request
module rr_arbiter (
  input  logic [1:0] req,
  input  logic       pri,
  output logic       grant
);
  assign grant = req[pri] ? pri : ~pri;
endmodule

// File: rtl/memory_bus_ctrl.sv
// memory_bus_ctrl: arbitrates both cores' icache/dcache traffic onto one RAM port
// and drives the snoop side toward the peer dcache
module memory_bus_ctrl
  import memory_bus_ctrl_pkg::*;
#(
  parameter int CPUS = 2
) (
  input  logic                      CLK,
  input  logic                      nRST,
  input  logic [CPUS-1:0]           iREN,
  input  logic [CPUS-1:0][31:0]     iaddr,
  output logic [CPUS-1:0]           iwait,
  output logic [CPUS-1:0][31:0]     iload,
  input  logic [CPUS-1:0]           dREN,
  input  logic [CPUS-1:0]           dWEN,
  input  logic [CPUS-1:0][31:0]     daddr,
  input  logic [CPUS-1:0][31:0]     dstore,
  output logic [CPUS-1:0]           dwait,
  output logic [CPUS-1:0][31:0]     dload,
  input  logic [CPUS-1:0]           cctrans,
  input  logic [CPUS-1:0]           ccwrite,
  output logic [CPUS-1:0]           ccwait,
  output logic [CPUS-1:0]           ccinv,
  output logic [CPUS-1:0][31:0]     ccsnoopaddr,
  output logic                      ramREN,
  output logic                      ramWEN,
  output logic [31:0]               ramaddr,
  output logic [31:0]               ramstore,
  input  logic [31:0]               ramload,
  input  logic [1:0]                ramstate
);
  bus_state_t state, next_state;
  logic r, next_r, s, dpri, ipri, dg, ig, access, leave;
  logic [CPUS-1:0] dreq;
  word_t blk_addr;
  assign s = ~r;
  assign access = ramstate == ACCESS;
  assign leave = state != IDLE && next_state == IDLE;
  // one dcache arbiter serves whichever request class currently has priority
  assign dreq = |dWEN ? dWEN : |cctrans ? cctrans : dREN;
  rr_arbiter u_darb (.req(dreq), .pri(dpri), .grant(dg));
  rr_arbiter u_iarb (.req(iREN), .pri(ipri), .grant(ig));
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state <= IDLE;
      r <= 1'b0;
      dpri <= 1'b0;
      ipri <= 1'b0;
    end else begin
      state <= next_state;
      r <= next_r;
      dpri <= (leave && state != IFETCH) ? ~r : dpri;
      ipri <= (leave && state == IFETCH) ? ~r : ipri;
    end
  end
  always_comb begin
    next_state = state;
    next_r = r;
    case (state)
      IDLE: begin
        next_r = |dreq ? dg : ig;
        next_state = |dWEN ? WB1 : |cctrans ? INV : |dREN ? SNOOP : |iREN ? IFETCH : IDLE;
      end
      WB1:        next_state = !dWEN[r] ? IDLE : access ? WB2 : WB1;
      WB2:        next_state = (!dWEN[r] || access) ? IDLE : WB2;
      INV:        next_state = IDLE;
      SNOOP:      next_state = ccwrite[s] ? C2C1 : RAM1;
      C2C1:       next_state = !dREN[r] ? IDLE : access ? C2C2 : C2C1;
      RAM1:       next_state = !dREN[r] ? IDLE : access ? RAM2 : RAM1;
      C2C2, RAM2: next_state = (!dREN[r] || access) ? IDLE : state;
      IFETCH:     next_state = (!iREN[r] || access) ? IDLE : IFETCH;
      default:    next_state = IDLE;
    endcase
  end
  always_comb begin
    iwait = '1;
    dwait = '1;
    ccwait = '0;
    ccinv = '0;
    ccsnoopaddr = '0;
    ramREN = 1'b0;
    ramWEN = 1'b0;
    ramaddr = '0;
    ramstore = '0;
    iload = {CPUS{ramload}};
    dload = {CPUS{ramload}};
    blk_addr = {daddr[r][31:3], state == C2C2, 2'b00};
    if (nRST) begin
      case (state)
        WB1, WB2: begin
          ramWEN = 1'b1;
          ramaddr = daddr[r];
          ramstore = dstore[r];
          dwait[r] = ~(access & dWEN[r]);
        end
        INV: begin
          ccwait[s] = 1'b1;
          ccinv[s] = 1'b1;
          ccsnoopaddr[s] = daddr[r];
        end
        SNOOP: begin
          ccwait[s] = 1'b1;
          ccsnoopaddr[s] = daddr[r];
        end
        // dirty peer supplies the block and memory is updated in the same cycle
        C2C1, C2C2: begin
          ccwait[s] = 1'b1;
          ccsnoopaddr[s] = blk_addr;
          dload[r] = dstore[s];
          ramWEN = 1'b1;
          ramaddr = blk_addr;
          ramstore = dstore[s];
          dwait[r] = ~(access & dREN[r]);
        end
        RAM1, RAM2: begin
          ramREN = 1'b1;
          ramaddr = daddr[r];
          dwait[r] = ~(access & dREN[r]);
        end
        IFETCH: begin
          ramREN = 1'b1;
          ramaddr = iaddr[r];
          iwait[r] = ~(access & iREN[r]);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_memory_bus_ctrl.sv
// tb_memory_bus_ctrl: random two-core traffic rounds checked against a transaction-order model
module tb_memory_bus_ctrl;
  import memory_bus_ctrl_pkg::*;
  localparam int K_NONE = 0, K_WB = 1, K_INV = 2, K_RD = 3, K_IF = 4;
  typedef struct packed {
    logic [7:0]  tag;
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  strb;
  } ev_t;
  logic CLK = 1'b0, nRST;
  logic [1:0] iREN, dREN, dWEN, cctrans, ccwrite, iwait, dwait, ccwait, ccinv;
  logic [1:0][31:0] iaddr, iload, daddr, dstore, dload, ccsnoopaddr;
  logic ramREN, ramWEN;
  logic [31:0] ramaddr, ramstore, ramload;
  logic [1:0] ramstate;
  logic [1:0] busy_left = 2'd0;
  logic [31:0] ram [64];
  logic [31:0] mm [64];
  int n_pass = 0, n_chk = 0;
  int kind [2], word [2];
  int mdp = 0, mip = 0;
  logic [31:0] base [2], ia [2];
  logic [31:0] wbd [2][2], pd [2][2];
  logic dirty [2];
  ev_t exp_q [$];
  always #5 CLK = ~CLK;
  memory_bus_ctrl dut (
    .CLK(CLK), .nRST(nRST), .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dwait(dwait), .dload(dload),
    .cctrans(cctrans), .ccwrite(ccwrite), .ccwait(ccwait), .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );
  // RAM with a random 0..3 cycle wait per access; a count of 3 shows ERROR first
  assign ramstate = !(ramREN || ramWEN) ? FREE : busy_left == 2'd0 ? ACCESS :
                    busy_left == 2'd3 ? ERROR : BUSY;
  assign ramload = ram[ramaddr[7:2]];
  always @(posedge CLK)
    if ((ramREN || ramWEN) && busy_left == 2'd0) begin
      busy_left <= 2'($urandom_range(0, 3));
      if (ramWEN) ram[ramaddr[7:2]] <= ramstore;
    end else if (ramREN || ramWEN) busy_left <= busy_left - 2'd1;
  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic drive();
    for (int c = 0; c < 2; c++) begin
      dWEN[c] = kind[c] == K_WB;
      dREN[c] = kind[c] == K_RD;
      cctrans[c] = kind[c] == K_INV;
      iREN[c] = kind[c] == K_IF;
      daddr[c] = base[c] + 32'(word[c] * 4);
      dstore[c] = wbd[c][word[c]];
      iaddr[c] = ia[c];
      ccwrite[c] = dirty[c];
    end
  endtask
  task automatic observe(int c, int k, logic [31:0] a, logic [31:0] d);
    ev_t e;
    chk("pending", 64'(exp_q.size() != 0), 1);
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    chk("who", {4'(c), 4'(k)}, e.tag);
    chk("addr", a, e.addr);
    chk("data", d, e.data);
    chk("strb", {ramREN, ramWEN}, e.strb);
  endtask
  task automatic step();
    @(negedge CLK);
    drive();
    #1;
    for (int c = 0; c < 2; c++) if (ccwait[c]) dstore[c] = pd[c][ccsnoopaddr[c][2]];
    #1;
    chk("excl", ramREN & ramWEN, 0);
    for (int c = 0; c < 2; c++) begin
      if (!dwait[c]) begin
        observe(c, kind[c], ramaddr, kind[c] == K_WB ? ramstore : dload[c]);
        word[c] = word[c] == 0 ? 1 : 0;
        kind[c] = word[c] == 0 ? K_NONE : kind[c];
      end
      if (!iwait[c]) begin
        observe(c, K_IF, ramaddr, iload[c]);
        kind[c] = K_NONE;
      end
      if (ccinv[c]) begin
        observe(1 - c, K_INV, ccsnoopaddr[c], {30'd0, ccwait[c], ccinv[c]});
        kind[1 - c] = K_NONE;
        if (kind[c] == K_INV) kind[c] = K_NONE;
      end
    end
  endtask
  task automatic emit(int w, int k);
    logic [31:0] a;
    logic [7:0] tag;
    tag = {4'(w), 4'(k)};
    if (k == K_INV) exp_q.push_back(ev_t'{tag, base[w], 32'd3, 2'b00});
    if (k == K_IF) exp_q.push_back(ev_t'{tag, ia[w], mm[ia[w][7:2]], 2'b10});
    if (k == K_WB || k == K_RD)
      for (int i = 0; i < 2; i++) begin
        a = base[w] + 32'(i * 4);
        if (k == K_WB) begin
          mm[a[7:2]] = wbd[w][i];
          exp_q.push_back(ev_t'{tag, a, wbd[w][i], 2'b01});
        end else if (dirty[1 - w]) begin
          mm[a[7:2]] = pd[1 - w][i];
          exp_q.push_back(ev_t'{tag, a, pd[1 - w][i], 2'b01});
        end else exp_q.push_back(ev_t'{tag, a, mm[a[7:2]], 2'b10});
      end
  endtask
  // service order: writeback > invalidate > fill > ifetch, ties broken by the class pointer
  task automatic plan();
    int k [2];
    int top, w;
    k[0] = kind[0];
    k[1] = kind[1];
    while (k[0] != K_NONE || k[1] != K_NONE) begin
      top = k[0] == K_NONE ? k[1] : k[1] == K_NONE ? k[0] : (k[0] < k[1] ? k[0] : k[1]);
      w = (k[0] == top && k[1] == top) ? (top == K_IF ? mip : mdp) : (k[0] == top ? 0 : 1);
      emit(w, top);
      if (top == K_IF) mip = 1 - w;
      else mdp = 1 - w;
      k[w] = K_NONE;
      if (top == K_INV && k[1 - w] == K_INV) k[1 - w] = K_NONE;
    end
  endtask
  initial begin
    int cyc;
    for (int i = 0; i < 64; i++) begin
      ram[i] = $urandom;
      mm[i] = ram[i];
    end
    for (int c = 0; c < 2; c++) begin
      kind[c] = K_NONE;
      word[c] = 0;
      base[c] = '0;
      ia[c] = '0;
      dirty[c] = 1'b0;
      for (int i = 0; i < 2; i++) begin
        wbd[c][i] = '0;
        pd[c][i] = '0;
      end
    end
    nRST = 1'b0;
    drive();
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    #1;
    chk("rst_dwait", dwait, 2'b11);
    chk("rst_iwait", iwait, 2'b11);
    chk("rst_cc", {ccwait, ccinv}, 0);
    chk("rst_ram", {ramREN, ramWEN, ramaddr}, 0);
    nRST = 1'b1;
    kind[0] = K_RD;
    base[0] = 32'h100;
    for (cyc = 0; cyc < 100; cyc++) begin
      @(negedge CLK);
      drive();
      #2;
      if (ramREN && ramaddr == 32'h104) break;
      if (!dwait[0]) word[0] = 1;
    end
    chk("reach_ram2", 64'(cyc < 100), 1);
    nRST = 1'b0;
    @(negedge CLK);
    #1;
    chk("midrst_ram", {ramREN, ramWEN}, 0);
    chk("midrst_dwait", dwait, 2'b11);
    chk("midrst_ccwait", ccwait, 0);
    kind[0] = K_NONE;
    word[0] = 0;
    drive();
    nRST = 1'b1;
    #1;
    chk("post_rst_idle", {ramREN, ramWEN, ccwait, dwait}, 6'b000011);
    for (int rnd = 0; rnd < 150; rnd++) begin
      for (int c = 0; c < 2; c++) begin
        kind[c] = $urandom_range(0, 4);
        word[c] = 0;
        base[c] = (32'($urandom_range(0, 3)) << 12) | (32'($urandom_range(0, 31)) << 3);
        ia[c] = (32'($urandom_range(0, 3)) << 12) | (32'($urandom_range(0, 63)) << 2);
        dirty[c] = 1'($urandom_range(0, 1));
        for (int i = 0; i < 2; i++) begin
          wbd[c][i] = $urandom;
          pd[c][i] = $urandom;
        end
      end
      if (kind[0] == K_INV && kind[1] == K_INV && $urandom_range(0, 1) == 1) base[1] = base[0];
      plan();
      for (cyc = 0; cyc < 300 && (kind[0] != K_NONE || kind[1] != K_NONE); cyc++) step();
      chk("round_done", 64'(cyc < 300), 1);
      kind[0] = K_NONE;
      kind[1] = K_NONE;
      word[0] = 0;
      word[1] = 0;
      repeat (2) step();
      chk("leftover", 64'(exp_q.size()), 0);
      exp_q.delete();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
